// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and skid buffer
// One outstanding imem request; redirect flushes and restarts fetch.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_KILL} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            valid_n;
  logic [XLEN-1:0] if_pc_n, if_instr_n;
  logic [XLEN-1:0] skid_instr, skid_instr_n, skid_pc, skid_pc_n;
  logic            slot_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= NOP_INSTR;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      if_valid   <= valid_n;
      if_pc      <= if_pc_n;
      if_instr   <= if_instr_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    valid_n      = if_valid;
    if_pc_n      = if_pc;
    if_instr_n   = if_instr;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    slot_free    = !if_valid || !stall;

    // An unstalled consumer drains the slot unless something new loads below.
    if (!stall) begin
      valid_n    = 1'b0;
      if_instr_n = NOP_INSTR;
    end

    case (state)
      S_REQ: begin
        if (imem_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (slot_free) begin
            valid_n    = 1'b1;
            if_pc_n    = pc;
            if_instr_n = imem_rdata;
            pc_n       = pc + XLEN'(4);
            state_n    = S_REQ;
          end else begin
            skid_instr_n = imem_rdata;
            skid_pc_n    = pc;
            state_n      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          valid_n    = 1'b1;
          if_pc_n    = skid_pc;
          if_instr_n = skid_instr;
          pc_n       = pc + XLEN'(4);
          state_n    = S_REQ;
        end
      end
      S_KILL: begin
        if (imem_rsp_valid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase

    // Redirect wins over everything; a response landing this cycle is stale.
    if (redirect_valid) begin
      pc_n       = {redirect_pc[XLEN-1:2], 2'b00};
      valid_n    = 1'b0;
      if_instr_n = NOP_INSTR;
      case (state)
        S_REQ:          state_n = imem_req_ready ? S_KILL : S_REQ;
        S_WAIT, S_KILL: state_n = imem_rsp_valid ? S_REQ : S_KILL;
        default:        state_n = S_REQ;
      endcase
    end
  end

  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_addr      = pc;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign funct3 = if_instr[14:12];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign funct7 = if_instr[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage
// Memory responder plus a program-order scoreboard of delivered instructions.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Memory: samples the handshake before the edge, answers after lat cycles.
  int          lat = 1;
  bit          poison = 1'b0;
  bit          ready_rand = 1'b0;
  int          cnt = 0;
  bit          hs;
  logic [31:0] haddr, pend;

  initial begin : memory
    forever begin
      @(negedge clk); #2;
      hs    = imem_req_valid && imem_req_ready;
      haddr = imem_addr;
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      if (hs) begin
        check("one_outstanding", cnt, 0);
        cnt  = lat;
        pend = haddr;
      end
      if (cnt > 0) begin
        if (cnt == 1) begin
          imem_rsp_valid = 1'b1;
          imem_rdata     = poison ? 32'hDEAD_BEEF : mem_word(pend);
        end
        cnt--;
      end
      imem_req_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_req(input logic [31:0] a, input string tag);
    int n = 0;
    #1;
    while (!(imem_req_valid && imem_req_ready) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, imem_req_valid, 1);
    check(tag, imem_addr, a);
  endtask

  task automatic fetch_one(input logic [31:0] a, input string tag);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!if_valid && n < 50);
    check({tag, "_valid"}, if_valid, 1);
    check({tag, "_pc"}, if_pc, a);
    check({tag, "_instr"}, if_instr, mem_word(a));
  endtask

  logic [31:0] exp_pc, target, prev_addr;
  bit          s, r, prev_pend, prev_redir;
  int          delivered;

  initial begin : main
    // Reset state
    step(); step(); step();
    check("rst_if_valid", if_valid, 0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_if_pc", if_pc, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_opcode", opcode, 7'h13);
    rst = 1'b0;

    // First fetch with 1-cycle memory
    expect_req(32'h0, "req0");
    step(); step();
    check("t1_if_valid", if_valid, 1);
    check("t1_if_pc", if_pc, 0);
    check("t1_opcode", opcode, 7'h13);
    check("t1_rd", rd, 1);
    check("t1_rs1", rs1, 0);
    check("t1_funct3", funct3, 0);
    check("t1_rs2", rs2, 5);
    check("t1_funct7", funct7, 0);
    check("t1_req_valid", imem_req_valid, 1);
    check("t1_req_addr", imem_addr, 32'h4);

    // Stall while @0x4 returns: held in skid
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_instr", if_instr, 32'h0050_0093);
      check("t2_hold_pc", if_pc, 0);
      check("t2_no_req", imem_req_valid, 0);
    end
    stall = 1'b0;
    step();
    check("t2_if_valid", if_valid, 1);
    check("t2_if_pc", if_pc, 32'h4);
    check("t2_if_instr", if_instr, mem_word(32'h4));
    check("t2_req_addr", imem_addr, 32'h8);

    // Redirect in WAIT; stale response discarded
    lat = 4; poison = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_if_valid", if_valid, 0);
      check("t3_no_req", imem_req_valid, 0);
      step();
    end
    check("t3_after_stale_valid", if_valid, 0);
    check("t3_req_addr", imem_addr, 32'h100);
    check("t3_req_valid", imem_req_valid, 1);
    poison = 1'b0; lat = 1;
    fetch_one(32'h100, "t3_fetch");

    // Redirect coinciding with rsp_valid while stalled
    stall = 1'b1; lat = 2;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("t4_if_valid", if_valid, 0);
    check("t4_if_instr", if_instr, NOP);
    check("t4_req_valid", imem_req_valid, 1);
    check("t4_req_addr", imem_addr, 32'h200);
    stall = 1'b0; lat = 1;
    fetch_one(32'h200, "t4_fetch");

    // Wraparound, with low bits of redirect_pc ignored
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    check("t5_kill_no_req", imem_req_valid, 0);
    expect_req(32'hFFFF_FFFC, "t5_req_top");
    fetch_one(32'hFFFF_FFFC, "t5_fetch_top");
    expect_req(32'h0, "t5_req_wrap");
    fetch_one(32'h0, "t5_fetch_wrap");

    // Reset while in HOLD
    stall = 1'b1;
    step(); step(); step(); step();
    check("t6_hold_valid", if_valid, 1);
    check("t6_hold_no_req", imem_req_valid, 0);
    rst = 1'b1;
    step();
    check("t6_rst_valid", if_valid, 0);
    check("t6_rst_instr", if_instr, NOP);
    check("t6_rst_pc", if_pc, 0);
    check("t6_rst_req", imem_req_valid, 0);
    rst = 1'b0; stall = 1'b0;
    expect_req(RESET_PC, "t6_req");
    fetch_one(RESET_PC, "t6_fetch");

    // Random phase: delivered stream must follow program order from the last redirect
    exp_pc = RESET_PC + 32'd4;
    delivered = 0; prev_pend = 1'b0; prev_redir = 1'b0; prev_addr = '0;
    ready_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (prev_pend && !prev_redir) begin
        check("rnd_addr_hold_valid", imem_req_valid, 1);
        check("rnd_addr_hold", imem_addr, prev_addr);
      end
      if (imem_req_valid) check("rnd_addr_align", imem_addr[1:0], 0);
      s = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 39) == 0);
      target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
      if (if_valid && !s && !r) begin
        check("rnd_pc", if_pc, exp_pc);
        check("rnd_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (r) exp_pc = target & ~32'h3;
      prev_pend  = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_addr;
      prev_redir = r;
      stall = s; redirect_valid = r; redirect_pc = target;
      lat = $urandom_range(1, 4);
    end
    stall = 1'b0; redirect_valid = 1'b0;
    check("rnd_progress", delivered > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
